// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the fetch PC, issues in-order word reads and buffers {word, pc} for decode.
// Optional FETCH_MISALIGN_CHK_EN: a misaligned redirect target yields one flagged NOP and halts fetch.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_misalign
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] { S_BOOT, S_FETCH, S_DRAIN } state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [31:0]   fifo_data_q [FIFO_DEPTH];
    logic [31:0]   fifo_data_d [FIFO_DEPTH];
    logic [31:0]   fifo_pc_q   [FIFO_DEPTH];
    logic [31:0]   fifo_pc_d   [FIFO_DEPTH];
    logic [CW-1:0] fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
    logic [31:0]   pcq_q [FIFO_DEPTH];
    logic [31:0]   pcq_d [FIFO_DEPTH];
    logic [CW-1:0] pcq_wr_q, pcq_wr_d, pcq_rd_q, pcq_rd_d;
`ifdef FETCH_MISALIGN_CHK_EN
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic          fifo_mis_q [FIFO_DEPTH];
    logic          fifo_mis_d [FIFO_DEPTH];
    logic          halt_q, halt_d;
    logic          redirect_mis;
`endif

    logic [CW-1:0] fifo_count;
    logic [CW:0]   credit_used;
    logic          req_fire, rsp_drop, rsp_keep, pop;

    assign fifo_count  = fifo_wr_q - fifo_rd_q;
    // Every outstanding request owns a FIFO slot, so the buffer can never overflow.
    assign credit_used = {1'b0, inflight_q} + {1'b0, fifo_count};
`ifdef FETCH_MISALIGN_CHK_EN
    assign redirect_mis = redirect_valid && (redirect_pc[1:0] != 2'b00);
`endif

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_BOOT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT:  state_d = S_FETCH;
            S_FETCH: if (redirect_valid && drop_cnt_d != '0) state_d = S_DRAIN;
            S_DRAIN: if (drop_cnt_d == '0) state_d = S_FETCH;
            default: state_d = S_BOOT;
        endcase
    end

    always_comb begin
        mem_req_valid = (state_q == S_FETCH) && (credit_used < (CW+1)'(FIFO_DEPTH))
`ifdef FETCH_MISALIGN_CHK_EN
                        && !halt_q
`endif
                        ;
        mem_req_addr  = {fetch_pc_q[31:2], 2'b00};
        instr_valid   = (fifo_count != '0);
        instr         = instr_valid ? fifo_data_q[fifo_rd_q[AW-1:0]] : 32'h0;
        instr_pc      = instr_valid ? fifo_pc_q[fifo_rd_q[AW-1:0]] : 32'h0;
`ifdef FETCH_MISALIGN_CHK_EN
        instr_misalign = instr_valid && fifo_mis_q[fifo_rd_q[AW-1:0]];
`else
        instr_misalign = 1'b0;
`endif
    end

    always_comb begin
        req_fire   = mem_req_valid && mem_req_ready;
        pop        = instr_valid && instr_ready;
        rsp_drop   = mem_rsp_valid && (drop_cnt_q != '0);
        rsp_keep   = mem_rsp_valid && (drop_cnt_q == '0) && !redirect_valid;
        inflight_d = inflight_q + CW'(req_fire) - CW'(mem_rsp_valid);
        fetch_pc_d = fetch_pc_q;
        drop_cnt_d = drop_cnt_q;
        fifo_data_d = fifo_data_q;
        fifo_pc_d   = fifo_pc_q;
        fifo_wr_d   = fifo_wr_q;
        fifo_rd_d   = fifo_rd_q;
        pcq_d       = pcq_q;
        pcq_wr_d    = pcq_wr_q;
        pcq_rd_d    = pcq_rd_q;
`ifdef FETCH_MISALIGN_CHK_EN
        fifo_mis_d  = fifo_mis_q;
        halt_d      = halt_q;
`endif
        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            pcq_d[pcq_wr_q[AW-1:0]] = fetch_pc_q;
            pcq_wr_d = pcq_wr_q + CW'(1);
        end
        if (rsp_drop) drop_cnt_d = drop_cnt_q - CW'(1);
        if (rsp_keep) begin
            fifo_data_d[fifo_wr_q[AW-1:0]] = mem_rsp_data;
            fifo_pc_d[fifo_wr_q[AW-1:0]]   = pcq_q[pcq_rd_q[AW-1:0]];
`ifdef FETCH_MISALIGN_CHK_EN
            fifo_mis_d[fifo_wr_q[AW-1:0]]  = 1'b0;
`endif
            fifo_wr_d = fifo_wr_q + CW'(1);
            pcq_rd_d  = pcq_rd_q + CW'(1);
        end
        if (pop) fifo_rd_d = fifo_rd_q + CW'(1);
        // Redirect wins: everything still in flight, including this cycle's accept, is stale.
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            drop_cnt_d = inflight_d;
            fifo_wr_d  = '0;
            fifo_rd_d  = '0;
            pcq_wr_d   = '0;
            pcq_rd_d   = '0;
`ifdef FETCH_MISALIGN_CHK_EN
            halt_d = redirect_mis;
            if (redirect_mis) begin
                fifo_data_d[0] = NOP;
                fifo_pc_d[0]   = redirect_pc;
                fifo_mis_d[0]  = 1'b1;
                fifo_wr_d      = CW'(1);
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q  <= RESET_PC;
            inflight_q  <= '0;
            drop_cnt_q  <= '0;
            fifo_data_q <= '{default: '0};
            fifo_pc_q   <= '{default: '0};
            fifo_wr_q   <= '0;
            fifo_rd_q   <= '0;
            pcq_q       <= '{default: '0};
            pcq_wr_q    <= '0;
            pcq_rd_q    <= '0;
`ifdef FETCH_MISALIGN_CHK_EN
            fifo_mis_q  <= '{default: 1'b0};
            halt_q      <= 1'b0;
`endif
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            inflight_q  <= inflight_d;
            drop_cnt_q  <= drop_cnt_d;
            fifo_data_q <= fifo_data_d;
            fifo_pc_q   <= fifo_pc_d;
            fifo_wr_q   <= fifo_wr_d;
            fifo_rd_q   <= fifo_rd_d;
            pcq_q       <= pcq_d;
            pcq_wr_q    <= pcq_wr_d;
            pcq_rd_q    <= pcq_rd_d;
`ifdef FETCH_MISALIGN_CHK_EN
            fifo_mis_q  <= fifo_mis_d;
            halt_q      <= halt_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && rsp_keep) assert (fifo_count < CW'(FIFO_DEPTH));
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an in-order fixed-latency memory model.
// Set FETCH_MISALIGN_CHK_EN to exercise the misaligned-redirect halt path.
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b1;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_misalign;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 1;
    int acc_cnt = 0;
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    logic [31:0] log_pc[$];
    logic [31:0] log_data[$];

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc), .instr_misalign(instr_misalign)
    );

    // Memory: word at addr reads back as addr + 0x1000_0000, returned lat cycles after accept.
    always @(negedge clk) begin
        #2;
        cyc = cyc + 1;
        if (reset) begin
            mq_addr.delete();
            mq_due.delete();
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = 32'h0;
            acc_cnt = 0;
        end else begin
            if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = mq_addr[0] + 32'h1000_0000;
                void'(mq_addr.pop_front());
                void'(mq_due.pop_front());
            end else begin
                mem_rsp_valid = 1'b0;
                mem_rsp_data  = 32'h0;
            end
            if (mem_req_valid && mem_req_ready) begin
                mq_addr.push_back(mem_req_addr);
                mq_due.push_back(cyc + lat);
                acc_cnt = acc_cnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        #3;
        if (!reset && instr_valid && instr_ready) begin
            log_pc.push_back(instr_pc);
            log_data.push_back(instr);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lpc(input int i);
        return (i < log_pc.size()) ? log_pc[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] ldat(input int i);
        return (i < log_data.size()) ? log_data[i] : 32'hDEAD_BEEF;
    endfunction

    // Leaves the bench in cycle 0 (state S_BOOT) with reset just released.
    task automatic do_reset();
        reset = 1'b1;
        redirect_valid = 1'b0;
        log_pc.delete();
        log_data.delete();
        step(2);
        chkb("rst_req_valid", mem_req_valid, 1'b0);
        chkb("rst_instr_valid", instr_valid, 1'b0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chkb("rst_misalign", instr_misalign, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        // Basic stream, latency 1
        lat = 1; mem_req_ready = 1'b1; instr_ready = 1'b1;
        do_reset();
        chkb("boot_no_req", mem_req_valid, 1'b0);
        step(1);
        chkb("a_c1_req", mem_req_valid, 1'b1);
        chk("a_c1_addr", mem_req_addr, 32'h0);
        step(1);
        chkb("a_c2_req", mem_req_valid, 1'b1);
        chk("a_c2_addr", mem_req_addr, 32'h4);
        chkb("a_c2_ivalid", instr_valid, 1'b0);
        step(1);
        chkb("a_c3_ivalid", instr_valid, 1'b1);
        chk("a_c3_pc", instr_pc, 32'h0);
        chk("a_c3_instr", instr, 32'h1000_0000);
        chkb("a_c3_credit_stall", mem_req_valid, 1'b0);
        step(1);
        chk("a_c4_pc", instr_pc, 32'h4);
        chk("a_c4_instr", instr, 32'h1000_0004);
        chkb("a_c4_req", mem_req_valid, 1'b1);
        chk("a_c4_addr", mem_req_addr, 32'h8);

        // Decode stalled: credits cap outstanding work at FIFO_DEPTH
        instr_ready = 1'b0;
        do_reset();
        step(6);
        chk("b_accepts", 32'(acc_cnt), 32'd2);
        chkb("b_req_stalled", mem_req_valid, 1'b0);
        chkb("b_ivalid", instr_valid, 1'b1);
        chk("b_head_pc", instr_pc, 32'h0);
        instr_ready = 1'b1;
        step(12);
        chk("b_pc0", lpc(0), 32'h0);
        chk("b_pc1", lpc(1), 32'h4);
        chk("b_pc2", lpc(2), 32'h8);
        chk("b_pc3", lpc(3), 32'hC);
        chk("b_dat2", ldat(2), 32'h1000_0008);

        // Redirect with two requests outstanding, latency 3
        lat = 3;
        do_reset();
        step(3);
        chkb("c_c3_req", mem_req_valid, 1'b0);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        step(1);
        redirect_valid = 1'b0;
        chkb("c_c4_req", mem_req_valid, 1'b0);
        chkb("c_c4_ivalid", instr_valid, 1'b0);
        step(1);
        chkb("c_c5_req", mem_req_valid, 1'b0);
        step(1);
        chkb("c_c6_req", mem_req_valid, 1'b1);
        chk("c_c6_addr", mem_req_addr, 32'h100);
        step(10);
        chk("c_pc0", lpc(0), 32'h100);
        chk("c_dat0", ldat(0), 32'h1000_0100);
        chk("c_pc1", lpc(1), 32'h104);

        // Redirect coinciding with an accept and a response
        lat = 1;
        do_reset();
        step(2);
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        step(1);
        redirect_valid = 1'b0;
        chkb("d_c3_ivalid", instr_valid, 1'b0);
        chkb("d_c3_req", mem_req_valid, 1'b0);
        step(1);
        chkb("d_c4_req", mem_req_valid, 1'b1);
        chk("d_c4_addr", mem_req_addr, 32'h200);
        step(6);
        chk("d_pc0", lpc(0), 32'h200);
        chk("d_dat0", ldat(0), 32'h1000_0200);

        // Fetch address wraps past the top of memory
        do_reset();
        mem_req_ready = 1'b0;
        step(1);
        chk("e_c1_addr", mem_req_addr, 32'h0);
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step(1);
        redirect_valid = 1'b0;
        mem_req_ready = 1'b1;
        chkb("e_c2_req", mem_req_valid, 1'b1);
        chk("e_c2_addr", mem_req_addr, 32'hFFFF_FFFC);
        step(1);
        chkb("e_c3_req", mem_req_valid, 1'b1);
        chk("e_c3_addr_wrap", mem_req_addr, 32'h0);
        step(4);
        chk("e_pc0", lpc(0), 32'hFFFF_FFFC);
        chk("e_dat0", ldat(0), 32'h0FFF_FFFC);

        // Misaligned redirect target
        instr_ready = 1'b0;
        do_reset();
        mem_req_ready = 1'b0;
        step(1);
        redirect_valid = 1'b1; redirect_pc = 32'h102;
        step(1);
        redirect_valid = 1'b0;
        mem_req_ready = 1'b1;
`ifdef FETCH_MISALIGN_CHK_EN
        chkb("f_c2_req", mem_req_valid, 1'b0);
        chkb("f_c2_ivalid", instr_valid, 1'b1);
        chk("f_c2_instr", instr, 32'h0000_0013);
        chk("f_c2_pc", instr_pc, 32'h102);
        chkb("f_c2_mis", instr_misalign, 1'b1);
        step(2);
        chk("f_accepts", 32'(acc_cnt), 32'd0);
        chkb("f_c4_req", mem_req_valid, 1'b0);
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        step(1);
        redirect_valid = 1'b0;
        chkb("f_c5_ivalid", instr_valid, 1'b0);
        chkb("f_c5_req", mem_req_valid, 1'b1);
        chk("f_c5_addr", mem_req_addr, 32'h200);
`else
        chkb("f_c2_req", mem_req_valid, 1'b1);
        chk("f_c2_addr", mem_req_addr, 32'h100);
        step(1);
        chk("f_c3_addr", mem_req_addr, 32'h104);
        step(1);
        chkb("f_c4_ivalid", instr_valid, 1'b1);
        chk("f_c4_pc", instr_pc, 32'h102);
        chk("f_c4_instr", instr, 32'h1000_0100);
        chkb("f_c4_mis", instr_misalign, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
